// File: rtl/store_queue_fwd_if.sv
// Core-side bundle for the store queue: allocate, commit/flush, Dcache drain
// and load-forwarding lookup. The core drives "master", the queue uses "slave".
interface store_queue_fwd_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int ROBW  = 6,
  parameter int RETN  = 4
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int RNW = $clog2(RETN + 1);

  logic            InAble;
  logic [AW-1:0]   InAddr;
  logic [DW-1:0]   InData;
  logic [1:0]      InSize;
  logic [1:0]      InMat;
  logic [ROBW-1:0] InRobPtr;
  logic            InReady;
  logic [PW-1:0]   InSbPtr;
  logic [RNW-1:0]  RetirNum;
  logic            SbFlush;
  logic            DcReq;
  logic [AW-1:0]   DcAddr;
  logic [DW-1:0]   DcData;
  logic [DW/8-1:0] DcMask;
  logic [1:0]      DcMat;
  logic            DcAck;
  logic            LdAble;
  logic [AW-1:0]   LdAddr;
  logic [1:0]      LdSize;
  logic            LdHit;
  logic [DW-1:0]   LdData;
  logic            LdConflict;
  logic            Empty;
  logic            Full;
  logic [CW-1:0]   Count;

  modport master (
    output InAble, InAddr, InData, InSize, InMat, InRobPtr, RetirNum, SbFlush,
           DcAck, LdAble, LdAddr, LdSize,
    input  InReady, InSbPtr, DcReq, DcAddr, DcData, DcMask, DcMat,
           LdHit, LdData, LdConflict, Empty, Full, Count
  );

  modport slave (
    input  InAble, InAddr, InData, InSize, InMat, InRobPtr, RetirNum, SbFlush,
           DcAck, LdAble, LdAddr, LdSize,
    output InReady, InSbPtr, DcReq, DcAddr, DcData, DcMask, DcMat,
           LdHit, LdData, LdConflict, Empty, Full, Count
  );
endinterface

// File: rtl/store_queue_fwd.sv
// Circular store buffer: in-order allocate, ROB commit, one-per-cycle Dcache
// drain, byte-granular store-to-load forwarding and uncommitted-only flush.
module store_queue_fwd #(
  parameter int DEPTH = 8,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int ROBW  = 6,
  parameter int RETN  = 4
) (
  input logic              Clk,
  input logic              Rest,
  store_queue_fwd_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NB = DW / 8;

  typedef logic [CW-1:0] ptr_t;

  // head = oldest, cmt = oldest uncommitted, tail = next free; MSB is the wrap bit
  ptr_t head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;

  logic [AW-3:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [NB-1:0]   mask_q [DEPTH];
  logic [1:0]      mat_q  [DEPTH];
  logic [ROBW-1:0] rob_q  [DEPTH];

  logic [PW-1:0] head_idx, tail_idx;
  ptr_t          count, pending, commit_n;
  logic          full, dc_req, wr_en;
  logic [NB-1:0] in_mask, ld_mask, fwd_hit, covered;
  logic [DW-1:0] in_data, fwd_data;
  logic [PW-1:0] idx;
  logic          rob_unused;

  function automatic logic [NB-1:0] lane_mask(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return NB'(1) << a;
      2'd1:    return NB'(3) << {a[1], 1'b0};
      default: return '1;
    endcase
  endfunction

  assign head_idx = head_q[PW-1:0];
  assign tail_idx = tail_q[PW-1:0];
  assign count    = tail_q - head_q;
  assign pending  = tail_q - cmt_q;
  assign full     = (count == CW'(DEPTH));
  assign dc_req   = (head_q != cmt_q);

  assign bus.InReady = !full;
  assign bus.InSbPtr = tail_idx;
  assign bus.Full    = full;
  assign bus.Empty   = (count == '0);
  assign bus.Count   = count;

  // The ROB tag travels with the entry for the core's exception path only.
  assign rob_unused = ^rob_q[head_idx];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    head_d   = head_q;
    cmt_d    = cmt_q;
    tail_d   = tail_q;
    wr_en    = 1'b0;
    commit_n = (32'(bus.RetirNum) > 32'(pending)) ? pending : CW'(bus.RetirNum);
    cmt_d    = cmt_q + commit_n;
    // Flush discards the allocate and rewinds tail onto the post-commit boundary.
    if (bus.SbFlush) begin
      tail_d = cmt_d;
    end else if (bus.InAble && !full) begin
      wr_en  = 1'b1;
      tail_d = tail_q + 1'b1;
    end
    if (dc_req && bus.DcAck) head_d = head_q + 1'b1;
  end

  always_comb begin
    in_mask = lane_mask(bus.InAddr[1:0], bus.InSize);
    in_data = (bus.InSize == 2'd0 || bus.InSize == 2'd1)
              ? (bus.InData << {bus.InAddr[1:0], 3'b000}) : bus.InData;
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (Rest) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      cmt_q  <= cmt_d;
      tail_q <= tail_d;
    end
  end

  // NOTE: entry storage has no reset; validity comes solely from the pointers.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      addr_q[tail_idx] <= bus.InAddr[AW-1:2];
      data_q[tail_idx] <= in_data;
      mask_q[tail_idx] <= in_mask;
      mat_q[tail_idx]  <= bus.InMat;
      rob_q[tail_idx]  <= bus.InRobPtr;
    end
  end

  always_comb begin
    bus.DcReq  = dc_req;
    bus.DcAddr = '0;
    bus.DcData = '0;
    bus.DcMask = '0;
    bus.DcMat  = '0;
    if (dc_req) begin
      bus.DcAddr = {addr_q[head_idx], 2'b00};
      bus.DcData = data_q[head_idx];
      bus.DcMask = mask_q[head_idx];
      bus.DcMat  = mat_q[head_idx];
    end
  end

  // Walk oldest to youngest so a younger matching byte overrides an older one.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + PW'(k);
      if (CW'(k) < count && addr_q[idx] == bus.LdAddr[AW-1:2]) begin
        for (int b = 0; b < NB; b++) begin
          if (mask_q[idx][b]) begin
            fwd_hit[b]        = 1'b1;
            fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    ld_mask        = lane_mask(bus.LdAddr[1:0], bus.LdSize);
    covered        = fwd_hit & ld_mask;
    bus.LdHit      = bus.LdAble && (covered == ld_mask);
    bus.LdConflict = bus.LdAble && (covered != '0) && (covered != ld_mask);
    bus.LdData     = '0;
    for (int b = 0; b < NB; b++) begin
      if (bus.LdAble && covered[b]) bus.LdData[8*b +: 8] = fwd_data[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_store_queue_fwd.sv
// Self-checking bench for store_queue_fwd: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_store_queue_fwd;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int ROBW  = 6;
  localparam int RETN  = 4;

  logic Clk = 1'b0;
  logic Rest;
  always #5 Clk = ~Clk;

  store_queue_fwd_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .ROBW(ROBW), .RETN(RETN)) sq_if ();
  store_queue_fwd #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .ROBW(ROBW), .RETN(RETN)) dut (
    .Clk (Clk),
    .Rest(Rest),
    .bus (sq_if)
  );

  typedef struct {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  mat;
  } ent_t;

  ent_t sq[$];
  int   ncmt;
  int   head_idx;
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [3:0] size_mask(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sq_if.InAble   = 1'b0;
    sq_if.InAddr   = '0;
    sq_if.InData   = '0;
    sq_if.InSize   = '0;
    sq_if.InMat    = '0;
    sq_if.InRobPtr = '0;
    sq_if.RetirNum = '0;
    sq_if.SbFlush  = 1'b0;
    sq_if.DcAck    = 1'b0;
    sq_if.LdAble   = 1'b0;
    sq_if.LdAddr   = '0;
    sq_if.LdSize   = '0;
  endtask

  task automatic set_alloc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input logic [1:0] mat);
    sq_if.InAble   = 1'b1;
    sq_if.InAddr   = a;
    sq_if.InData   = d;
    sq_if.InSize   = sz;
    sq_if.InMat    = mat;
    sq_if.InRobPtr = 6'($urandom);
  endtask

  // Reference model: one cycle of queue behaviour from the inputs present at the edge.
  task automatic model_step();
    int   size, c;
    bit   do_ack, do_alloc;
    ent_t e;
    if (Rest) begin
      sq.delete();
      ncmt     = 0;
      head_idx = 0;
      return;
    end
    size     = sq.size();
    c        = (int'(sq_if.RetirNum) < size - ncmt) ? int'(sq_if.RetirNum) : size - ncmt;
    do_ack   = (ncmt > 0) && sq_if.DcAck;
    do_alloc = sq_if.InAble && (size < DEPTH) && !sq_if.SbFlush;
    ncmt += c;
    if (sq_if.SbFlush) while (sq.size() > ncmt) void'(sq.pop_back());
    if (do_alloc) begin
      e.waddr = sq_if.InAddr[31:2];
      e.mask  = size_mask(sq_if.InAddr[1:0], sq_if.InSize);
      e.data  = (sq_if.InSize == 2'd2) ? sq_if.InData : sq_if.InData << (8 * sq_if.InAddr[1:0]);
      e.mat   = sq_if.InMat;
      sq.push_back(e);
    end
    if (do_ack) begin
      void'(sq.pop_front());
      ncmt--;
      head_idx = (head_idx + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [3:0]  lm, cov;
    logic [31:0] ld;
    bit          found;
    int          n;
    n = sq.size();
    check({tag, ".count"}, sq_if.Count, n);
    check({tag, ".empty"}, sq_if.Empty, n == 0);
    check({tag, ".full"}, sq_if.Full, n == DEPTH);
    check({tag, ".ready"}, sq_if.InReady, n != DEPTH);
    check({tag, ".sbptr"}, sq_if.InSbPtr, (head_idx + n) % DEPTH);
    check({tag, ".dcreq"}, sq_if.DcReq, ncmt > 0);
    check({tag, ".dcaddr"}, sq_if.DcAddr, (ncmt > 0) ? {sq[0].waddr, 2'b00} : 32'h0);
    check({tag, ".dcdata"}, sq_if.DcData, (ncmt > 0) ? sq[0].data : 32'h0);
    check({tag, ".dcmask"}, sq_if.DcMask, (ncmt > 0) ? sq[0].mask : 4'h0);
    check({tag, ".dcmat"}, sq_if.DcMat, (ncmt > 0) ? sq[0].mat : 2'h0);
    lm  = size_mask(sq_if.LdAddr[1:0], sq_if.LdSize);
    cov = '0;
    ld  = '0;
    for (int b = 0; b < 4; b++) begin
      found = 1'b0;
      for (int j = n - 1; j >= 0 && !found; j--) begin
        if (lm[b] && sq[j].waddr == sq_if.LdAddr[31:2] && sq[j].mask[b]) begin
          found        = 1'b1;
          cov[b]       = 1'b1;
          ld[8*b +: 8] = sq[j].data[8*b +: 8];
        end
      end
    end
    if (!sq_if.LdAble) ld = '0;
    check({tag, ".ldhit"}, sq_if.LdHit, sq_if.LdAble && cov == lm);
    check({tag, ".ldconf"}, sq_if.LdConflict, sq_if.LdAble && cov != 0 && cov != lm);
    check({tag, ".lddata"}, sq_if.LdData, ld);
  endtask

  task automatic do_reset();
    idle();
    Rest = 1'b1;
    tick();
    Rest = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sz;
    idle();
    Rest = 1'b0;
    sq.delete();
    ncmt     = 0;
    head_idx = 0;

    // Reset state, then three stores, commit two, drain with DcAck held high
    do_reset();
    check("rst.ready", sq_if.InReady, 1);
    check("rst.empty", sq_if.Empty, 1);
    check("rst.dcreq", sq_if.DcReq, 0);
    check_all("rst");
    for (int i = 0; i < 3; i++) begin
      set_alloc(32'h100 + 4 * i, $urandom, 2'd2, 2'(i));
      tick();
    end
    idle();
    sq_if.RetirNum = 3'd2;
    sq_if.DcAck    = 1'b1;
    #1 check("t1.pre_commit.dcreq", sq_if.DcReq, 0);
    tick();
    sq_if.RetirNum = 3'd0;
    #1 check("t1.dcaddr0", sq_if.DcAddr, 32'h100);
    check_all("t1.c0");
    tick();
    check("t1.dcaddr1", sq_if.DcAddr, 32'h104);
    check_all("t1.c1");
    tick();
    check("t1.dcreq_drop", sq_if.DcReq, 0);
    check("t1.count", sq_if.Count, 1);
    check_all("t1.c2");

    // Fill to DEPTH, then a ninth allocate that must be dropped
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(32'h200 + 4 * i, $urandom, 2'd2, 2'd1);
      tick();
    end
    idle();
    #1 check("t2.full", sq_if.Full, 1);
    check("t2.ready", sq_if.InReady, 0);
    set_alloc(32'h900, 32'hDEADBEEF, 2'd2, 2'd3);
    tick();
    idle();
    check("t2.count_hold", sq_if.Count, 8);
    check_all("t2.after9");
    sq_if.RetirNum = 3'd4;
    sq_if.DcAck    = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      check("t2.drain_addr", sq_if.DcAddr, 32'h200 + 4 * k);
      check_all("t2.drain");
      tick();
    end
    check("t2.empty", sq_if.Empty, 1);

    // Forwarding: word + younger byte merge, miss, partial conflict, byte hit
    do_reset();
    set_alloc(32'h100, 32'hAABBCCDD, 2'd2, 2'd0);
    tick();
    set_alloc(32'h101, 32'h11, 2'd0, 2'd0);
    tick();
    idle();
    sq_if.LdAble = 1'b1;
    sq_if.LdAddr = 32'h100;
    sq_if.LdSize = 2'd2;
    #1 check("t3.w100.hit", sq_if.LdHit, 1);
    check("t3.w100.data", sq_if.LdData, 32'hAABB11DD);
    check_all("t3.w100");
    sq_if.LdAddr = 32'h104;
    #1 check("t3.w104.hit", sq_if.LdHit, 0);
    check("t3.w104.conf", sq_if.LdConflict, 0);
    set_alloc(32'h105, 32'h22, 2'd0, 2'd0);
    tick();
    sq_if.InAble = 1'b0;
    #1 check("t3.w104b.conf", sq_if.LdConflict, 1);
    check("t3.w104b.hit", sq_if.LdHit, 0);
    sq_if.LdAddr = 32'h105;
    sq_if.LdSize = 2'd0;
    #1 check("t3.b105.hit", sq_if.LdHit, 1);
    check("t3.b105.data", sq_if.LdData, 32'h00002200);
    check_all("t3.b105");

    // Flush with two committed, three uncommitted
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc(32'h300 + 4 * i, $urandom, 2'd2, 2'd2);
      tick();
    end
    idle();
    sq_if.RetirNum = 3'd2;
    tick();
    sq_if.RetirNum = 3'd0;
    sq_if.SbFlush  = 1'b1;
    tick();
    sq_if.SbFlush = 1'b0;
    #1 check("t4.count", sq_if.Count, 2);
    check("t4.sbptr", sq_if.InSbPtr, 2);
    sq_if.DcAck = 1'b1;
    #1 check("t4.drain0", sq_if.DcAddr, 32'h300);
    tick();
    check("t4.drain1", sq_if.DcAddr, 32'h304);
    tick();
    check("t4.empty", sq_if.Empty, 1);
    check_all("t4.end");

    // Back-to-back alloc/commit/ack across wrap, then reset mid-drain
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_alloc(32'h400 + 4 * (i % 16), $urandom, 2'd2, 2'(i));
      sq_if.RetirNum = 3'd1;
      sq_if.DcAck    = 1'b1;
      #1 check_all("t5.b2b");
      tick();
    end
    set_alloc(32'h480, $urandom, 2'd2, 2'd0);
    sq_if.RetirNum = 3'd1;
    sq_if.DcAck    = 1'b0;
    tick();
    idle();
    #1 check("t5.pre_rst.dcreq", sq_if.DcReq, 1);
    Rest = 1'b1;
    tick();
    Rest = 1'b0;
    #1 check("t5.rst.dcreq", sq_if.DcReq, 0);
    check("t5.rst.count", sq_if.Count, 0);
    check("t5.rst.sbptr", sq_if.InSbPtr, 0);
    check_all("t5.rst");

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      if (sz == 2'd0) a[1:0] = 2'($urandom);
      if (sz == 2'd1) a[1]   = 1'($urandom);
      d = $urandom;
      if (sz == 2'd0) d = d & 32'hFF;
      if (sz == 2'd1) d = d & 32'hFFFF;
      if ($urandom_range(0, 2) != 0) set_alloc(a, d, sz, 2'($urandom));
      else sq_if.InAble = 1'b0;
      sq_if.RetirNum = 3'($urandom_range(0, RETN));
      sq_if.DcAck    = 1'($urandom);
      sq_if.SbFlush  = ($urandom_range(0, 15) == 0);
      sq_if.LdAble   = 1'($urandom);
      sq_if.LdSize   = 2'($urandom_range(0, 2));
      sq_if.LdAddr   = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      if (sq_if.LdSize == 2'd0) sq_if.LdAddr[1:0] = 2'($urandom);
      if (sq_if.LdSize == 2'd1) sq_if.LdAddr[1]   = 1'($urandom);
      Rest = ($urandom_range(0, 63) == 0);
      #1 check_all("rnd");
      tick();
      Rest = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
